// File: rtl/instr_port_arbiter.sv
// Two-port arbiter for the instruction-memory req/gnt/rvalid port, with an in-order ID FIFO for response routing.
// Define INSTR_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 (core) has fixed priority.
module instr_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int RDATA_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   core_req_i,
  input  logic [ADDR_WIDTH-1:0]  core_addr_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  output logic [RDATA_WIDTH-1:0] core_rdata_o,
  input  logic                   dbg_req_i,
  input  logic [ADDR_WIDTH-1:0]  dbg_addr_i,
  output logic                   dbg_gnt_o,
  output logic                   dbg_rvalid_o,
  output logic [RDATA_WIDTH-1:0] dbg_rdata_o,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] mem_rdata_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {ARB, HOLD} state_e;

  state_e                     state_q, state_d;
  logic                       lock_sel_q, lock_sel_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
  logic                       err_q, err_d;

  logic sel;        // 0 = core, 1 = dbg
  logic sel_req;
  logic arb_pick;   // winner when both ports request in ARB
  logic full;
  logic push;
  logic pop;
  logic head_id;

`ifdef INSTR_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign arb_pick     = ~last_grant_q;
  assign last_grant_d = push ? sel : last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign arb_pick = 1'b0;
`endif

  always_comb begin
    sel = 1'b0;
    if (state_q == HOLD) begin
      sel = lock_sel_q;
    end else if (core_req_i && dbg_req_i) begin
      sel = arb_pick;
    end else begin
      sel = dbg_req_i;
    end
  end

  // full uses only the registered count, so there is no rvalid-to-req path.
  assign sel_req    = sel ? dbg_req_i : core_req_i;
  assign full       = (cnt_q == CNT_MAX);
  assign mem_req_o  = sel_req & ~full;
  assign mem_addr_o = sel ? dbg_addr_i : core_addr_i;

  assign push = mem_req_o & mem_gnt_i;
  assign pop  = mem_rvalid_i & (cnt_q != '0);

  assign core_gnt_o = push & ~sel & rst_n;
  assign dbg_gnt_o  = push & sel & rst_n;

  assign head_id       = ids_q[rd_ptr_q];
  assign core_rvalid_o = pop & ~head_id;
  assign dbg_rvalid_o  = pop & head_id;
  assign core_rdata_o  = mem_rdata_i;
  assign dbg_rdata_o   = mem_rdata_i;

  assign busy_o = (cnt_q != '0) | core_req_i | dbg_req_i;
  assign err_o  = err_q;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ids_d      = ids_q;
    err_d      = err_q | (mem_rvalid_i & (cnt_q == '0));

    case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d    = HOLD;
          lock_sel_d = sel;
        end
      end
      HOLD: begin
        // A dropped request in HOLD is a protocol violation; just release the lock.
        if (mem_gnt_i || !mem_req_o) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (push) begin
      ids_d[wr_ptr_q] = sel;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      lock_sel_q <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ids_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ids_q      <= ids_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/instr_port_arbiter.md
# instr_port_arbiter

Shares the single instruction-memory port (req/gnt/rvalid protocol) between the core's instruction fetch path (port 0, driven by the IF stage prefetch buffer) and a secondary requester (port 1, debug unit or loader).
It arbitrates requests and holds the selected request stable until it is granted.
It tracks outstanding transactions in an in-order ID FIFO so that each `rvalid`/`rdata` is routed back to the port that issued the request.
It sits between the IF stage and the instruction memory/cache.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, address width.
- `RDATA_WIDTH`, 32, read data width (32 or 128).
- `MAX_OUTSTANDING`, 2, maximum number of granted-but-unanswered transactions, range 1..4.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `core_req_i`  in  1  port-0 request.
- `core_addr_i`  in  ADDR_WIDTH  port-0 address.
- `core_gnt_o`  out  1  port-0 grant.
- `core_rvalid_o`  out  1  port-0 response valid.
- `core_rdata_o`  out  RDATA_WIDTH  port-0 response data.
- `dbg_req_i`, `dbg_addr_i`, `dbg_gnt_o`, `dbg_rvalid_o`, `dbg_rdata_o`: port-1 equivalents, same widths.
- `mem_req_o`  out  1  request to memory.
- `mem_addr_o`  out  ADDR_WIDTH  address to memory.
- `mem_gnt_i`  in  1  memory grant.
- `mem_rvalid_i`  in  1  memory response valid.
- `mem_rdata_i`  in  RDATA_WIDTH  memory response data.
- `busy_o`  out  1  outstanding count is nonzero, or any `*_req_i` is high.
- `err_o`  out  1  sticky: `mem_rvalid_i` arrived while no transaction was outstanding.

## Operation

**State machine** (`ARB`, `HOLD`), reset to `ARB`:
- `ARB`: a port is selected combinationally among the active requests.
  - Only one port requesting: that port is selected.
  - Both requesting: the policy in Configuration decides.
  - `mem_req_o` = `sel_req & ~full`. `mem_addr_o` = selected port's address.
  - If `mem_req_o` is high and `mem_gnt_i` is low, the state goes to `HOLD` and `lock_sel` is set to the selected port.
- `HOLD`:
  - The selection is forced to `lock_sel`, so `mem_addr_o` stays stable regardless of the other port.
  - On `mem_gnt_i`, return to `ARB`.
  - If the locked port drops its request (protocol violation), `mem_req_o` follows it low and the state returns to `ARB` next cycle.
  - `full` cannot rise in `HOLD` because no grant occurs there.

**Grants:**
- `<sel>_gnt_o` = `mem_gnt_i & mem_req_o & (sel == port)`.
- The other port's grant is 0.

**ID FIFO:**
- Depth `MAX_OUTSTANDING`, 1 bit per entry (port ID), with count register `cnt` (0..`MAX_OUTSTANDING`).
- Push the selected ID on an accepted grant. Pop on `mem_rvalid_i` when `cnt` is nonzero.
- `full` = (`cnt == MAX_OUTSTANDING`).
- `full` is taken from the registered count only. A pop in the same cycle does not unblock a request; there is no `rvalid`-to-`req` combinational path.
- Simultaneous push and pop leaves `cnt` unchanged. Pointers wrap modulo `MAX_OUTSTANDING`.

**Responses:**
- `core_rdata_o` = `dbg_rdata_o` = `mem_rdata_i` (broadcast).
- `<port>_rvalid_o` = `mem_rvalid_i & (cnt != 0) & (head ID == port)`.
- Responses are strictly in order.
- `mem_rvalid_i` with `cnt == 0`: both rvalids stay 0 and `err_o` is set. `err_o` clears only on reset.

## Timing

- Zero-cycle combinational paths:
  - `*_req_i` → `mem_req_o`/`mem_addr_o`
  - `mem_gnt_i` → `*_gnt_o`
  - `mem_rvalid_i` → `*_rvalid_o`
- The arbitration decision and `last_grant` update take effect on the clock edge of an accepted grant.
- Reset values: state `ARB`, `cnt` 0, FIFO pointers 0, `last_grant` = port 1 (so port 0 wins the first contention), `err_o` 0.
- Resulting outputs during reset: all `*_gnt_o`/`*_rvalid_o` 0. `mem_req_o` and `busy_o` follow the inputs combinationally.
- Reset mid-operation discards the outstanding IDs. Responses arriving afterwards set `err_o`.

## Configuration

- `INSTR_ARB_ROUND_ROBIN_EN` defined:
  - On contention in `ARB`, the port not recorded in `last_grant` wins.
  - `last_grant` updates on every accepted grant.
- Not defined:
  - Fixed priority: port 0 (core) always wins contention.
  - `last_grant` is not implemented.
  - Port 1 is served only when port 0 is idle or the state is `HOLD` locked on port 1.

## Test plan

- **Single fetch:** `core_req_i`=1, addr 0x0000_0080, `mem_gnt_i`=1 in the same cycle; next cycle `mem_rvalid_i`=1, rdata 0xDEADBEEF → `core_gnt_o`=1, `mem_addr_o`=0x80, then `core_rvalid_o`=1 with 0xDEADBEEF, `dbg_rvalid_o`=0.
- **Round-robin (macro on):** both ports request continuously, gnt every cycle, rvalid one cycle later → grant order core, dbg, core, dbg; rvalids routed in the same order. With the macro off → core on every grant.
- **Hold:** dbg alone requests addr 0x100, `mem_gnt_i`=0 for 3 cycles; core raises its request with addr 0x200 in cycle 1 → `mem_addr_o` stays 0x100 until gnt, then core is granted 0x200.
- **Full:** `MAX_OUTSTANDING`=2, two grants with no rvalid → `mem_req_o`=0 and `core_gnt_o`=0 while core still requests. One rvalid → `mem_req_o`=1 on the following cycle.
- **Ordering with overlap:** grant core (0x10), then dbg (0x20); rvalids return 0xA, then 0xB → `core_rvalid_o` with 0xA, then `dbg_rvalid_o` with 0xB.
- **Spurious response:** `mem_rvalid_i`=1 with `cnt`=0 → both rvalids 0, `err_o`=1 and held until `rst_n` is asserted.
